// File: rtl/imem_pkg.sv
// Shared definitions for the single-line instruction fetch buffer.
package imem_pkg;

    localparam int LINE_WORDS_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/imem_line_store.sv
// One buffered line: tag, valid bit and word array, with one write port and a
// combinational read port.
module imem_line_store
    import imem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    localparam int IDX_W = $clog2(LINE_WORDS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_valid,
    input  logic             commit,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             commit_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] tag,
    output logic             valid,
    output logic [31:0]      rd_data
);

    logic [31:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            tag   <= '0;
            valid <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                words[wr_idx] <= wr_data;
            end
            // commit and clear_valid come from different fill states, never together
            if (commit) begin
                tag   <= commit_tag;
                valid <= commit_valid;
            end else if (clear_valid) begin
                valid <= 1'b0;
            end
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/imem_fetch_buffer.sv
// Single-line instruction fetch buffer: hits are answered combinationally, a
// miss fills the whole line in order from backing memory.
module imem_fetch_buffer
    import imem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic        flush,
    output logic [31:0] i_data,
    output logic        i_valid,
    output logic        stall_req,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    fill_state_t      state, next_state;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] beat;
    logic             discard;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] line_tag;
    logic             line_valid;
    logic [31:0]      line_word;
    logic             line_hit;
    logic             last_ack;
    logic             start_fill;
    logic             unused_low;

    assign addr_tag   = i_addr[31:2+IDX_W];
    assign addr_idx   = i_addr[1+IDX_W:2];
    assign unused_low = ^i_addr[1:0];

    assign line_hit = (state == IDLE) && line_valid && (line_tag == addr_tag);
    assign last_ack = (state == FILL) && mem_ack && (beat == LAST_BEAT);

    // Memory handshake: mem_req/mem_addr hold steady while FILL waits; a beat
    // transfers on every rising edge where mem_req and mem_ack are both high.
    always_comb begin
        next_state = state;
        start_fill = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !line_hit) begin
                    next_state = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                if (last_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fill_tag <= '0;
            beat     <= '0;
            discard  <= 1'b0;
        end else begin
            state <= next_state;
            if (start_fill) begin
                fill_tag <= addr_tag;
                beat     <= '0;
                discard  <= 1'b0;
            end
            if (state == FILL) begin
                if (flush) begin
                    discard <= 1'b1;
                end
                if (mem_ack) begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    imem_line_store #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_store (
        .clk          (clk),
        .reset        (reset),
        .clear_valid  (!reset && ((state == IDLE && flush) || start_fill)),
        .commit       (!reset && last_ack),
        .commit_tag   (fill_tag),
        .commit_valid (!(discard || flush)),
        .wr_en        (!reset && (state == FILL) && mem_ack),
        .wr_idx       (beat),
        .wr_data      (mem_rdata),
        .rd_idx       (addr_idx),
        .tag          (line_tag),
        .valid        (line_valid),
        .rd_data      (line_word)
    );

    // Reset masks the outputs in the same cycle so nothing escapes from the old state.
    assign i_valid   = line_hit && !reset;
    assign i_data    = i_valid ? line_word : 32'h0;
    assign stall_req = !i_valid;
    assign mem_req   = (state == FILL) && !reset;
    assign mem_addr  = mem_req ? {fill_tag, beat, 2'b00} : 32'h0;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed bench for imem_fetch_buffer with a line-level reference model and
// a scoreboard of expected memory beat addresses.
module tb_imem_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr;
    logic        flush;
    logic [31:0] i_data;
    logic        i_valid;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_period = 1;
    int wait_cnt   = 0;
    int req_cycles = 0;
    int cyc;
    logic [31:0] exp_q[$];

    imem_fetch_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (i_addr),
        .flush     (flush),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .stall_req (stall_req),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks required finish", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:4], 4'h0} + 32'hA0 + {30'd0, a[3:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(i * 4));
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input int max, output int stalled);
        stalled = 0;
        @(negedge clk);
        while (!i_valid && stalled < max) begin
            stalled++;
            @(negedge clk);
        end
        if (!i_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_hit: i_valid got 0 required 1 within %0d cycles", max);
        end
    endtask

    // backing memory: acks every ack_period-th cycle of an outstanding request
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req === 1'b1) begin
                wait_cnt++;
                mem_ack = (wait_cnt >= ack_period);
                if (mem_ack) wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        end
    end

    // reference model: whole-line view built from byte addresses
    logic        m_busy, m_valid, m_discard;
    int          m_beat;
    logic [31:0] m_fill_base, m_line_base;
    logic [31:0] m_words [4];

    function automatic logic m_hit();
        return !m_busy && m_valid && ((i_addr & ~32'hF) == m_line_base);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_discard = 1'b0; m_beat = 0;
            m_fill_base = 32'h0; m_line_base = 32'h0;
            for (int i = 0; i < 4; i++) m_words[i] = 32'h0;
        end else if (m_busy) begin
            if (flush) m_discard = 1'b1;
            if (mem_ack) begin
                m_words[m_beat] = mem_rdata;
                m_beat++;
                if (m_beat == 4) begin
                    m_busy      = 1'b0;
                    m_line_base = m_fill_base;
                    m_valid     = !m_discard;
                end
            end
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (!m_hit()) begin
            m_busy      = 1'b1;
            m_fill_base = i_addr & ~32'hF;
            m_beat      = 0;
            m_valid     = 1'b0;
            m_discard   = 1'b0;
        end
    end

    // per-cycle compare and beat scoreboard
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ed;
        if (reset) begin
            check("rst_i_valid", 32'(i_valid), 32'd0);
            check("rst_stall", 32'(stall_req), 32'd1);
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_mem_addr", mem_addr, 32'h0);
        end else begin
            ev = m_hit();
            ed = ev ? m_words[i_addr[3:2]] : 32'h0;
            check("i_valid", 32'(i_valid), 32'(ev));
            check("i_data", i_data, ed);
            check("stall_req", 32'(stall_req), 32'(!ev));
            check("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) check("mem_addr", mem_addr, m_fill_base + 32'(m_beat * 4));
        end
        if (mem_req === 1'b1) req_cycles++;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_addr: got unexpected beat %h required none", mem_addr);
            end else begin
                check("beat_addr", mem_addr, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset  = 1'b1;
        flush  = 1'b0;
        i_addr = 32'h0;
        repeat (2) drive_edge();
        @(negedge clk);
        check("reset_i_data", i_data, 32'h0);
        check("reset_stall", 32'(stall_req), 32'd1);

        // cold miss
        drive_edge();
        reset  = 1'b0;
        i_addr = 32'h0000_0008;
        push_line(32'h0);
        wait_hit(30, cyc);
        check("cold_penalty", 32'(cyc), 32'd5);
        check("cold_data", i_data, 32'hA2);

        // hit streak
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            i_addr = 32'(k * 4);
            @(negedge clk);
            check("streak_valid", 32'(i_valid), 32'd1);
            check("streak_data", i_data, 32'hA0 + 32'(k));
            check("streak_mem_req", 32'(mem_req), 32'd0);
        end

        // slow memory
        drive_edge();
        ack_period = 3;
        i_addr     = 32'h100;
        req_cycles = 0;
        push_line(32'h100);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("slow_hold_addr", mem_addr, 32'h100);
        end
        wait_hit(40, cyc);
        check("slow_fill_cycles", 32'(req_cycles), 32'd12);
        check("slow_data", i_data, 32'h1A0);
        drive_edge();
        ack_period = 1;

        // address change mid-fill
        i_addr = 32'h200;
        push_line(32'h200);
        repeat (3) @(posedge clk);
        #1;
        i_addr = 32'h300;
        push_line(32'h300);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("gap_mem_req", 32'(mem_req), 32'd0);
        check("gap_stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        check("next_mem_req", 32'(mem_req), 32'd1);
        check("next_mem_addr", mem_addr, 32'h300);
        wait_hit(20, cyc);
        check("next_data", i_data, 32'h3A0);

        // flush mid-fill
        drive_edge();
        i_addr = 32'h400;
        push_line(32'h400);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        drive_edge();
        flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("discard_stall", 32'(stall_req), 32'd1);
        check("discard_mem_req", 32'(mem_req), 32'd0);
        push_line(32'h400);
        @(negedge clk);
        check("refill_mem_req", 32'(mem_req), 32'd1);
        check("refill_mem_addr", mem_addr, 32'h400);
        wait_hit(20, cyc);
        check("refill_data", i_data, 32'h4A0);

        // flush in IDLE, held across a miss so it blocks the fill
        drive_edge();
        flush = 1'b1;
        @(negedge clk);
        check("flush_still_hit", 32'(i_valid), 32'd1);
        drive_edge();
        @(negedge clk);
        check("flush_miss_no_req", 32'(mem_req), 32'd0);
        drive_edge();
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_no_req", 32'(mem_req), 32'd0);
        push_line(32'h400);
        wait_hit(20, cyc);
        check("post_flush_data", i_data, 32'h4A0);

        // reset mid-fill
        drive_edge();
        i_addr = 32'h500;
        exp_q.push_back(32'h500);
        exp_q.push_back(32'h504);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_fill_mem_req", 32'(mem_req), 32'd0);
        check("rst_fill_stall", 32'(stall_req), 32'd1);
        drive_edge();
        reset = 1'b0;
        push_line(32'h500);
        wait_hit(20, cyc);
        check("restart_data", i_data, 32'h5A0);
        drive_edge();
        i_addr = 32'h50C;
        @(negedge clk);
        check("restart_last_word", i_data, 32'h5A3);

        drive_edge();
        check("beats_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_buffer.md
IMEM_FETCH_BUFFER -- requirements
Module: imem_fetch_buffer

Interface
REQ-001 Parameter: LINE_WORDS, 4, words per line; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: i_addr  input  32  byte address of the instruction requested by the fetch stage.
REQ-005 Port: flush  input  1  invalidates the buffered line.
REQ-006 Port: i_data  output  32  instruction word for i_addr.
REQ-007 Port: i_valid  output  1  i_data is valid in this cycle.
REQ-008 Port: stall_req  output  1  fetch stage must hold its PC; equals !i_valid.
REQ-009 Port: mem_req  output  1  backing-memory read request.
REQ-010 Port: mem_addr  output  32  word-aligned byte address of the current beat.
REQ-011 Port: mem_ack  input  1  backing memory delivers mem_rdata this cycle.
REQ-012 Port: mem_rdata  input  32  read data, valid when mem_ack=1.

Function
REQ-013 Buffer holds one line: tag (i_addr[31:2+log2(LINE_WORDS)]), valid bit, and LINE_WORDS data words.
REQ-014 Hit: valid=1, tag matches, and state IDLE; same-cycle combinational i_valid=1 and i_data=word[i_addr word-index bits].
REQ-015 i_addr[1:0] is ignored; misaligned addresses return the containing word.
REQ-016 When not hit: i_valid=0, i_data=32'h0, stall_req=1.
REQ-017 FSM states: IDLE and FILL only.
REQ-018 IDLE->FILL on the edge where there is a miss, no reset, and no flush. Latch the miss tag, set beat=0, clear valid.
REQ-019 In FILL: mem_req=1 and mem_addr={fill_tag, beat, 2'b00}, both stable until mem_ack.
REQ-020 Each mem_ack in FILL writes mem_rdata to word[beat] and increments beat.
REQ-021 Line fill order is always beat 0 to LINE_WORDS-1; there is no critical-word-first ordering.
REQ-022 On the ack of beat LINE_WORDS-1: FILL->IDLE, tag=fill_tag, and valid=1 unless discard is set. mem_req=0 in the following cycle.
REQ-023 mem_ack outside FILL is ignored.
REQ-024 i_addr changing during FILL does not abort the fill. The new address is evaluated in IDLE after completion, which can start a back-to-back fill with one IDLE cycle in between.
REQ-025 flush in IDLE clears valid at the next edge. flush has priority over a new miss, so no fill starts in that cycle.
REQ-026 flush during FILL sets discard. The fill completes but the line is left invalid.
REQ-027 flush together with the final ack: the line is left invalid.
REQ-028 discard is cleared on entry to FILL.
REQ-029 Minimum miss penalty: 1 cycle to enter FILL plus LINE_WORDS ack cycles, then hit in the first IDLE cycle.

Reset
REQ-030 reset asserted on an edge: state=IDLE, valid=0, discard=0, beat=0, tag=0, and data words=0.
REQ-031 While reset is high: mem_req=0 and mem_addr=0. i_valid, i_data and stall_req follow REQ-014/016 against the reset state, so i_valid=0 and stall_req=1.
REQ-032 Reset during FILL abandons the fill immediately. A mem_ack in the reset cycle is ignored.

Structure
REQ-033 Shared package imem_pkg defines the fill-state enum (IDLE, FILL) and LINE_WORDS_DEFAULT=4.
REQ-034 Sub-module imem_line_store (tag, valid, word array, write port, combinational read port) is instantiated once. The FSM stays in imem_fetch_buffer.

Verification
REQ-035 Cold miss: reset, then i_addr=0x0000_0008, ack every cycle, mem_rdata=0xA0+beat.
  - Required: mem_addr 0x0, 0x4, 0x8, 0xC.
  - Required: i_valid=1 with i_data=0xA2 on the cycle after the 4th ack.
  - Required: stall_req=1 throughout the fill.
REQ-036 Hit streak: after REQ-035, i_addr steps 0x0 to 0xC.
  - Required: i_valid=1 every cycle with data 0xA0 to 0xA3.
  - Required: mem_req=0 throughout.
REQ-037 Slow memory: i_addr=0x100, mem_ack every 3rd cycle.
  - Required: mem_addr stays at 0x100 until the first ack.
  - Required: FILL lasts 12 cycles, then hit at 0x100.
REQ-038 Address change mid-fill: i_addr=0x200, then 0x300 after beat 1.
  - Required: fill of 0x200-0x20C completes.
  - Required: one IDLE cycle follows, then mem_addr=0x300 with mem_req=1.
REQ-039 Flush mid-fill: flush=1 at beat 2 while filling 0x400.
  - Required: all 4 beats are requested.
  - Required: stall_req stays 1 afterwards and a new fill of 0x400 begins.
REQ-040 Reset mid-fill: reset at beat 2.
  - Required: next cycle mem_req=0 and stall_req=1.
  - Required: after release, the fill restarts at beat 0.
